// File: rtl/pc_seq_ras.sv
// Fetch-stage program-counter sequencer with a circular return-address stack.
// Next PC priority: trap, stall, redirect, return, jump/call, sequential.
module pc_seq_ras #(
  parameter int ADDR_W    = 10,
  parameter int RESET_VEC = 0,
  parameter int INC       = 1,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           trap,
  input  logic [ADDR_W-1:0]              trap_vec,
  input  logic                           redirect,
  input  logic [ADDR_W-1:0]              redirect_pc,
  input  logic                           ld,
  input  logic [ADDR_W-1:0]              ld_pc,
  input  logic                           call,
  input  logic                           ret,
  input  logic [ADDR_W-1:0]              ret_pc,
  output logic [ADDR_W-1:0]              pc,
  output logic [ADDR_W-1:0]              pc_4,
  output logic [$clog2(RAS_DEPTH):0]     ras_count,
  output logic                           ras_empty,
  output logic                           ras_full,
  output logic                           ras_hit
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  top_q, top_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
  logic              empty;
  logic [PTR_W-1:0]  top_inc;

  assign empty     = (cnt_q == '0);
  assign top_inc   = top_q + 1'b1;
  assign pc        = pc_q;
  assign pc_4      = pc_q + ADDR_W'(INC);
  assign ras_count = cnt_q;
  assign ras_empty = empty;
  assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
  assign ras_hit   = ret && !empty;

  // top_q indexes the newest valid entry; a push writes one slot above it,
  // so a full stack silently overwrites the oldest entry.
  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    top_d = top_q;
    ras_d = ras_q;
    if (trap) begin
      pc_d  = trap_vec;
      cnt_d = '0;
      top_d = '0;
    end else if (en) begin
      if (redirect) begin
        pc_d = redirect_pc;
      end else if (ret) begin
        pc_d = empty ? ret_pc : ras_q[top_q];
        if (ld && call) begin
          // Coroutine swap: replace the top in place, or seed an empty stack.
          if (empty) begin
            top_d          = top_inc;
            ras_d[top_inc] = pc_4;
            cnt_d          = CNT_W'(1);
          end else begin
            ras_d[top_q] = pc_4;
          end
        end else if (!empty) begin
          top_d = top_q - 1'b1;
          cnt_d = cnt_q - 1'b1;
        end
      end else if (ld) begin
        pc_d = ld_pc;
        if (call) begin
          top_d          = top_inc;
          ras_d[top_inc] = pc_4;
          if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + 1'b1;
        end
      end else begin
        pc_d = pc_4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= ADDR_W'(RESET_VEC);
      cnt_q <= '0;
      top_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      top_q <= top_d;
      ras_q <= ras_d;
    end
  end

endmodule

// File: tb/tb_pc_seq_ras.sv
// Directed bench for pc_seq_ras with the default 10-bit PC and 4-entry RAS.
module tb_pc_seq_ras;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n, en, trap, redirect, ld, call, ret;
  logic [AW-1:0] trap_vec, redirect_pc, ld_pc, ret_pc;
  logic [AW-1:0] pc, pc_4;
  logic [2:0]    ras_count;
  logic          ras_empty, ras_full, ras_hit;

  int n_pass = 0;
  int n_total = 0;

  pc_seq_ras dut (
    .clk(clk), .rst_n(rst_n), .en(en), .trap(trap), .trap_vec(trap_vec),
    .redirect(redirect), .redirect_pc(redirect_pc), .ld(ld), .ld_pc(ld_pc),
    .call(call), .ret(ret), .ret_pc(ret_pc), .pc(pc), .pc_4(pc_4),
    .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_hit(ras_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b1; trap = 1'b0; redirect = 1'b0; ld = 1'b0; call = 1'b0; ret = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; idle(); en = 1'b0;
    trap_vec = '0; redirect_pc = '0; ld_pc = '0; ret_pc = '0;
    #12;
    chk("rst_pc", pc, 0);
    chk("rst_cnt", ras_count, 0);
    chk("rst_empty", ras_empty, 1);
    chk("rst_full", ras_full, 0);
    chk("rst_pc4", pc_4, 1);
    rst_n = 1'b1;
    #2;

    idle();
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("seq_pc", pc, i);
    end

    en = 1'b0; ld = 1'b1; ld_pc = 10'h040;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc, 4);
    end
    en = 1'b1;
    tick();
    chk("ld_pc", pc, 10'h040);

    ld = 1'b0; en = 1'b0; trap = 1'b1; trap_vec = 10'h3F0;
    tick();
    chk("trap_pc", pc, 10'h3F0);
    chk("trap_cnt", ras_count, 0);

    idle(); ld = 1'b1; ld_pc = 10'h3FF;
    tick();
    chk("max_pc", pc, 10'h3FF);
    chk("wrap_pc4", pc_4, 0);
    ld = 1'b0;
    tick();
    chk("wrap_pc", pc, 0);

    ld = 1'b1; ld_pc = 10'h010;
    tick();
    call = 1'b1; ld_pc = 10'h080;
    tick();
    chk("call_pc", pc, 10'h080);
    chk("call_cnt", ras_count, 1);
    idle(); ret = 1'b1; ret_pc = 10'h055;
    #1;
    chk("ret_hit", ras_hit, 1);
    tick();
    chk("ret_pc", pc, 10'h011);
    chk("ret_cnt", ras_count, 0);
    chk("ret_miss_hit", ras_hit, 0);
    tick();
    chk("ret_empty_pc", pc, 10'h055);
    chk("ret_empty_cnt", ras_count, 0);

    // Five pushes into a four-deep stack: 0x56 is overwritten by 0x131.
    idle(); ld = 1'b1; call = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ld_pc = AW'(10'h100 + 10'h010 * i);
      tick();
    end
    chk("full_cnt", ras_count, 4);
    chk("full_flag", ras_full, 1);
    idle(); ret = 1'b1; ret_pc = 10'h077;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pop_pc", pc, 10'h131 - 10'h010 * i);
    end
    chk("pop_empty", ras_empty, 1);
    tick();
    chk("lost_pc", pc, 10'h077);

    idle(); ld = 1'b1; ld_pc = 10'h02F;
    tick();
    call = 1'b1; ld_pc = 10'h020;
    tick();
    chk("push30_cnt", ras_count, 1);
    redirect = 1'b1; redirect_pc = 10'h200; ret = 1'b1; ld_pc = 10'h099;
    tick();
    chk("redir_pc", pc, 10'h200);
    chk("redir_cnt", ras_count, 1);
    idle(); redirect = 1'b1; redirect_pc = 10'h020;
    tick();
    chk("redir2_pc", pc, 10'h020);

    idle(); ld = 1'b1; call = 1'b1; ret = 1'b1; ld_pc = 10'h099; ret_pc = 10'h066;
    tick();
    chk("swap_pc", pc, 10'h030);
    chk("swap_cnt", ras_count, 1);
    idle(); ret = 1'b1;
    tick();
    chk("swap_top", pc, 10'h021);
    idle(); ld = 1'b1; call = 1'b1; ret = 1'b1; ret_pc = 10'h066;
    tick();
    chk("swap_e_pc", pc, 10'h066);
    chk("swap_e_cnt", ras_count, 1);

    idle(); call = 1'b1;
    tick();
    chk("call_no_ld_pc", pc, 10'h067);
    chk("call_no_ld_cnt", ras_count, 1);

    idle(); trap = 1'b1; trap_vec = 10'h123;
    tick();
    chk("trap_clr_cnt", ras_count, 0);
    chk("trap_clr_pc", pc, 10'h123);

    idle();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pc", pc, 0);
    chk("async_rst_cnt", ras_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_pc", pc, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
